// File: rtl/trace_arg_parser.sv
// Byte-serial "+KEY=value" argument-line parser producing the FILE and MODE run-configuration words.
// Optional ARG_HEX_VALUE_EN: accepts "0x"/"0X"-prefixed hexadecimal values.
module trace_arg_parser #(
    parameter int              VAL_W        = 32,
    parameter logic [VAL_W-1:0] MODE_DEFAULT = '0,
    parameter logic [VAL_W-1:0] FILE_DEFAULT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arg_valid,
    input  logic [7:0]       arg_data,
    output logic [VAL_W-1:0] file,
    output logic [VAL_W-1:0] mode,
    output logic             verbose,
    output logic             args_done,
    output logic             arg_err,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_VAL, S_SKIP, S_DONE} state_t;

    state_t           state_q;
    logic [2:0]       idx_q;
    logic             m_mode_q, m_file_q, sel_file_q, have_q;
    logic [VAL_W-1:0] acc_q, file_q, mode_q;
    logic             verbose_q, done_q, err_q;
`ifdef ARG_HEX_VALUE_EN
    logic             hex_q, zero_q;
`endif

    logic             is_sep, is_nl, is_plus, is_eq, is_dig, val_dig;
    logic [7:0]       key_m, key_f;
    logic             m_mode_d, m_file_d;
    logic [VAL_W-1:0] acc_d;

    assign is_sep  = (arg_data == 8'h20) || (arg_data == 8'h09) ||
                     (arg_data == 8'h00) || (arg_data == 8'h0D);
    assign is_nl   = (arg_data == 8'h0A);
    assign is_plus = (arg_data == "+");
    assign is_eq   = (arg_data == "=");
    assign is_dig  = (arg_data >= "0") && (arg_data <= "9");

    // Both keys are 4 chars, so a single index walks them in lock-step.
    always_comb begin
        key_m = 8'h00;
        key_f = 8'h00;
        case (idx_q)
            3'd0: begin key_m = "M"; key_f = "F"; end
            3'd1: begin key_m = "O"; key_f = "I"; end
            3'd2: begin key_m = "D"; key_f = "L"; end
            3'd3: begin key_m = "E"; key_f = "E"; end
            default: ;
        endcase
    end

    assign m_mode_d = m_mode_q && (arg_data == key_m);
    assign m_file_d = m_file_q && (arg_data == key_f);

`ifdef ARG_HEX_VALUE_EN
    logic       is_hexa, is_x;
    logic [3:0] nib;
    assign is_hexa = ((arg_data >= "a") && (arg_data <= "f")) ||
                     ((arg_data >= "A") && (arg_data <= "F"));
    assign nib     = is_dig ? arg_data[3:0] : (arg_data[3:0] + 4'd9);
    assign is_x    = ((arg_data == "x") || (arg_data == "X")) && zero_q && !hex_q;
    assign val_dig = hex_q ? (is_dig || is_hexa) : is_dig;
    assign acc_d   = hex_q ? ((acc_q << 4) | VAL_W'(nib))
                           : ((acc_q << 3) + (acc_q << 1) + VAL_W'(arg_data[3:0]));
`else
    assign val_dig = is_dig;
    assign acc_d   = (acc_q << 3) + (acc_q << 1) + VAL_W'(arg_data[3:0]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            m_mode_q   <= 1'b0;
            m_file_q   <= 1'b0;
            sel_file_q <= 1'b0;
            have_q     <= 1'b0;
            acc_q      <= '0;
            file_q     <= FILE_DEFAULT;
            mode_q     <= MODE_DEFAULT;
            verbose_q  <= (MODE_DEFAULT == VAL_W'(1));
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef ARG_HEX_VALUE_EN
            hex_q      <= 1'b0;
            zero_q     <= 1'b0;
`endif
        end else if (arg_valid) begin
            // First byte after a newline opens a fresh line; later writes below may override.
            if (state_q == S_DONE) begin
                done_q    <= 1'b0;
                err_q     <= 1'b0;
                file_q    <= FILE_DEFAULT;
                mode_q    <= MODE_DEFAULT;
                verbose_q <= (MODE_DEFAULT == VAL_W'(1));
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (is_nl) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (is_plus) begin
                        state_q  <= S_KEY;
                        idx_q    <= '0;
                        m_mode_q <= 1'b1;
                        m_file_q <= 1'b1;
                        acc_q    <= '0;
                    end else if (is_sep) begin
                        state_q <= S_IDLE;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_SKIP;
                    end
                end
                S_KEY: begin
                    if (is_nl) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (is_sep) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (is_eq) begin
                        if ((idx_q == 3'd4) && (m_mode_q || m_file_q)) begin
                            state_q    <= S_VAL;
                            sel_file_q <= m_file_q;
                            acc_q      <= '0;
                            have_q     <= 1'b0;
`ifdef ARG_HEX_VALUE_EN
                            hex_q      <= 1'b0;
                            zero_q     <= 1'b0;
`endif
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_SKIP;
                        end
                    end else if ((idx_q == 3'd4) || !(m_mode_d || m_file_d)) begin
                        err_q   <= 1'b1;
                        state_q <= S_SKIP;
                    end else begin
                        idx_q    <= idx_q + 3'd1;
                        m_mode_q <= m_mode_d;
                        m_file_q <= m_file_d;
                    end
                end
                S_VAL: begin
                    if (is_sep || is_nl) begin
                        if (have_q) begin
                            if (sel_file_q) begin
                                file_q <= acc_q;
                            end else begin
                                mode_q    <= acc_q;
                                verbose_q <= (acc_q == VAL_W'(1));
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= is_nl ? S_DONE : S_IDLE;
                        if (is_nl) done_q <= 1'b1;
                    end else if (val_dig) begin
                        acc_q  <= acc_d;
                        have_q <= 1'b1;
`ifdef ARG_HEX_VALUE_EN
                        zero_q <= !have_q && (arg_data == "0");
                    end else if (is_x) begin
                        // "0x" restarts the value: the leading zero does not count as a digit.
                        hex_q  <= 1'b1;
                        have_q <= 1'b0;
                        acc_q  <= '0;
`endif
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_SKIP;
                    end
                end
                S_SKIP: begin
                    if (is_nl) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (is_sep) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign file      = file_q;
    assign mode      = mode_q;
    assign verbose   = verbose_q;
    assign args_done = done_q;
    assign arg_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_trace_arg_parser.sv
// Bench for trace_arg_parser: directed lines plus random argument lines scored against a token-level model.
module tb_trace_arg_parser;

`ifdef ARG_HEX_VALUE_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif
    localparam int W = 65;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arg_valid = 1'b0;
    logic [7:0]  arg_data = 8'h00;
    logic [31:0] file, mode;
    logic        verbose, args_done, arg_err;
    logic [2:0]  dbg_state;

    trace_arg_parser #(.VAL_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .arg_valid(arg_valid), .arg_data(arg_data),
        .file(file), .mode(mode), .verbose(verbose), .args_done(args_done),
        .arg_err(arg_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];
    byte unsigned line_q[$];
    byte unsigned tok_q[$];
    logic [31:0] mdl_file, mdl_mode;
    bit          mdl_err;
    bit          nl_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_sep_c(input byte unsigned c);
        return (c == 8'h20) || (c == 8'h09) || (c == 8'h00) || (c == 8'h0D);
    endfunction

    function automatic int hexval(input byte unsigned c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    function automatic void eval_token();
        int eq;
        bit is_mode, is_file, hex;
        longint unsigned v;
        int start, nv;
        eq = -1;
        if (tok_q[0] != "+") begin mdl_err = 1; return; end
        for (int i = 1; i < tok_q.size(); i++)
            if (eq < 0 && tok_q[i] == "=") eq = i;
        if (eq != 5) begin mdl_err = 1; return; end
        is_mode = tok_q[1] == "M" && tok_q[2] == "O" && tok_q[3] == "D" && tok_q[4] == "E";
        is_file = tok_q[1] == "F" && tok_q[2] == "I" && tok_q[3] == "L" && tok_q[4] == "E";
        if (!is_mode && !is_file) begin mdl_err = 1; return; end
        nv = tok_q.size() - 6;
        hex = HEX_EN && nv >= 2 && tok_q[6] == "0" && (tok_q[7] == "x" || tok_q[7] == "X");
        start = hex ? 8 : 6;
        if (start >= tok_q.size()) begin mdl_err = 1; return; end
        v = 0;
        for (int i = start; i < tok_q.size(); i++) begin
            if (hex) begin
                if (hexval(tok_q[i]) < 0) begin mdl_err = 1; return; end
                v = (v * 16 + longint'(hexval(tok_q[i]))) % 64'h1_0000_0000;
            end else begin
                if (tok_q[i] < "0" || tok_q[i] > "9") begin mdl_err = 1; return; end
                v = (v * 10 + longint'(tok_q[i] - 8'd48)) % 64'h1_0000_0000;
            end
        end
        if (is_file) mdl_file = v[31:0];
        else mdl_mode = v[31:0];
    endfunction

    function automatic void model_line();
        mdl_file = 0;
        mdl_mode = 0;
        mdl_err  = 0;
        tok_q.delete();
        foreach (line_q[i]) begin
            if (is_sep_c(line_q[i]) || line_q[i] == 8'h0A) begin
                if (tok_q.size() > 0) eval_token();
                tok_q.delete();
            end else begin
                tok_q.push_back(line_q[i]);
            end
        end
    endfunction

    // ---------------- line building and driving ----------------
    function automatic void push_str(input string s);
        for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
    endfunction

    function automatic void set_line(input string s);
        line_q.delete();
        push_str(s);
    endfunction

    task automatic prep_line();
        model_line();
        exp_q.push_back({mdl_file, mdl_mode, mdl_err});
    endtask

    task automatic send_byte(input byte unsigned b);
        @(negedge clk);
        arg_valid = 1'b1;
        arg_data  = b;
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    arg_valid = 1'b0;
                    arg_data  = 8'($urandom);
                end
            end
            send_byte(line_q[i]);
        end
        @(negedge clk);
        arg_valid = 1'b0;
    endtask

    task automatic send_line(input bit gaps);
        prep_line();
        send_range(0, line_q.size(), gaps);
    endtask

    function automatic void rand_sep();
        case ($urandom_range(0, 5))
            0: line_q.push_back(8'h09);
            1: line_q.push_back(8'h00);
            2: line_q.push_back(8'h0D);
            default: line_q.push_back(8'h20);
        endcase
    endfunction

    function automatic void push_key();
        push_str($urandom_range(0, 1) ? "+MODE=" : "+FILE=");
    endfunction

    function automatic void rand_line();
        string hexd;
        hexd = "0123456789abcdefABCDEF";
        line_q.delete();
        for (int t = 0; t < $urandom_range(0, 4); t++) begin
            if (t > 0 || $urandom_range(0, 3) == 0) rand_sep();
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    push_key();
                    push_str($sformatf("%0d", $urandom_range(0, 3) == 0 ? $urandom_range(0, 999) : $urandom_range(0, 2)));
                end
                4: begin
                    push_key();
                    for (int i = 0; i < $urandom_range(8, 12); i++) line_q.push_back(8'($urandom_range(48, 57)));
                end
                5: begin
                    push_key();
                    push_str($urandom_range(0, 1) ? "0x" : "0X");
                    for (int i = 0; i < $urandom_range(0, 9); i++) line_q.push_back(hexd[$urandom_range(0, 21)]);
                end
                6: case ($urandom_range(0, 3))
                       0: push_str("+MODX=5");
                       1: push_str("+FIL=2");
                       2: push_str("+MODEE=1");
                       default: push_str("+mode=1");
                   endcase
                7: push_key();
                8: begin
                    push_key();
                    push_str("1");
                    case ($urandom_range(0, 3))
                        0: push_str("a");
                        1: push_str("=");
                        2: push_str("x");
                        default: push_str("+");
                    endcase
                end
                default: push_str($urandom_range(0, 1) ? "abc" : "+MODE");
            endcase
        end
        line_q.push_back(8'h0A);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) nl_pending <= rst_n && arg_valid && (arg_data == 8'h0A);

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (nl_pending) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_line_end", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_file", 64'(file), 64'(e[64:33]));
                check("sb_mode", 64'(mode), 64'(e[32:1]));
                check("sb_verbose", 64'(verbose), 64'(e[32:1] == 32'd1));
                check("sb_err", 64'(arg_err), 64'(e[0]));
                check("sb_args_done", 64'(args_done), 64'd1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cycles;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_file", 64'(file), 64'd0);
        check("rst_mode", 64'(mode), 64'd0);
        check("rst_verbose", 64'(verbose), 64'd0);
        check("rst_args_done", 64'(args_done), 64'd0);
        check("rst_err", 64'(arg_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // File value lands the cycle after the separator is accepted.
        set_line("+FILE=3 +MODE=1\n");
        prep_line();
        send_range(0, 7, 1'b0);
        check("file_before_sep", 64'(file), 64'd0);
        send_range(7, 8, 1'b0);
        check("file_after_sep", 64'(file), 64'd3);
        send_range(8, line_q.size(), 1'b0);

        set_line("+MODE=0\n");            send_line(1'b0);
        set_line("+FILE=4294967297\n");   send_line(1'b0);
        set_line("+MODX=5 +FILE=\n");     send_line(1'b0);
        set_line("+MODE=7a\n");           send_line(1'b0);
        set_line("+MODE=2 +MODE=9\n");    send_line(1'b1);

        // New line reloads defaults on its first byte and drops args_done.
        set_line("+FILE=2\n");
        prep_line();
        send_range(0, 1, 1'b0);
        check("newline_args_done_low", 64'(args_done), 64'd0);
        check("newline_mode_reload", 64'(mode), 64'd0);
        send_range(1, line_q.size(), 1'b0);

        set_line("\n");                   send_line(1'b0);

        // Async reset in the middle of a line.
        set_line("+MODE=1 q +FILE=12");
        send_range(0, 15, 1'b0);
        check("pre_rst_verbose", 64'(verbose), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_file", 64'(file), 64'd0);
        check("midrst_mode", 64'(mode), 64'd0);
        check("midrst_verbose", 64'(verbose), 64'd0);
        check("midrst_err", 64'(arg_err), 64'd0);
        check("midrst_args_done", 64'(args_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_line("+FILE=5\n");            send_line(1'b0);
        set_line("+FILE=0x1F\n");         send_line(1'b0);
        set_line("+MODE=0x\n");           send_line(1'b0);
        set_line("+MODE=0X7 +FILE=0xfFFFFFFFF\n"); send_line(1'b0);

        for (int n = 0; n < 250; n++) begin
            rand_line();
            send_line($urandom_range(0, 1) == 1);
        end

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 100) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() != 0) check("sb_drain_timeout", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
